ram2_byte_reader: RTL and testbench
===================================

RAM2_BYTE_READER -- requirements
Module: ram2_byte_reader

Interface
REQ-001 SHALL provide parameter START_ADDR, default 13'd0, first RAM address read.
REQ-002 SHALL provide parameter LAST_ADDR, default 13'd8191, last RAM address read (inclusive).
REQ-003 SHALL provide parameter LSB_FIRST, default 1; 1 = symbol i packed into BYTE[2i+1:2i], 0 = into BYTE[7-2i:6-2i].
REQ-004 SHALL use one clock, and its reset SHALL be asynchronous and active-low: CLK  in  1  rising-edge clock; RST_N  in  1  async active-low reset.
REQ-005 START  in  1  single-cycle run request.
REQ-006 BUSY  out  1  run in progress.
REQ-007 DONE  out  1  one-cycle pulse, run complete.
REQ-008 RAM_ADDR  out  13  address to 2-bit block RAM.
REQ-009 RAM_EN  out  1  RAM enable, read issue / advance strobe.
REQ-010 RAM_WE, RAM_SSR  out  1 each  tied 0.
REQ-011 RAM_DO  in  2  RAM registered data output (1-cycle read latency, holds when RAM_EN=0).
REQ-012 BYTE  out  8  packed byte.
REQ-013 BYTE_VALID  out  1 / BYTE_READY  in  1  valid/ready output handshake; transfer when both high at a rising edge.

Function
REQ-014 FSM states IDLE, READ, DRAIN; IDLE->READ on START; READ->DRAIN after LAST_ADDR issued; DRAIN->IDLE when final byte transfers.
REQ-015 START SHALL be ignored when BUSY=1.
REQ-016 Advance condition adv = !BYTE_VALID || BYTE_READY; RAM_EN SHALL equal adv while issuing or while a symbol is pending, 0 otherwise.
REQ-017 adv=0 SHALL hold RAM_ADDR, symbol count, partial byte and BYTE unchanged; no symbol lost or duplicated.
REQ-018 Address SHALL increment by 1 modulo 8192 per issued read (8191 -> 0 wrap); symbols per run = ((LAST_ADDR-START_ADDR) mod 8192)+1.
REQ-019 Timing with BYTE_READY=1: START sampled at edge 0; RAM_EN=1 with RAM_ADDR=START_ADDR in cycle 1; 4th symbol in RAM_DO in cycle 5; BYTE_VALID=1 in cycle 6; one byte per 4 cycles thereafter.
REQ-020 BYTE_VALID SHALL stay high and BYTE stable until transfer.
REQ-021 A final partial byte (symbol count not multiple of 4) SHALL be emitted with unfilled positions 0.
REQ-022 DONE SHALL pulse in the cycle after the final byte transfers; BUSY SHALL be 1 from the cycle after START through the DONE cycle, 0 otherwise.
REQ-023 START coincident with DONE SHALL be ignored.

Reset
REQ-025 RST_N low SHALL immediately force IDLE, BUSY=0, DONE=0, BYTE_VALID=0, BYTE=0, RAM_EN=0, RAM_ADDR=0, counters 0, regardless of run state.
REQ-026 After RST_N release, the first START SHALL begin a fresh run from START_ADDR.

Structure
REQ-027 Shared package ram2_pkg SHALL hold ADDR_W=13, SYM_W=2, BYTE_W=8, SYMS_PER_BYTE=4 and the FSM state enum.
REQ-028 Sub-module sym_packer SHALL hold the 2-bit-to-byte packing register and the 2-bit symbol counter; FSM, addressing and handshake stay in ram2_byte_reader.

Verification
REQ-029 RAM[0..3]=0,1,2,3, START_ADDR=0, LAST_ADDR=3, READY=1: LSB_FIRST=1 -> BYTE=8'hE4, valid cycle 6, DONE cycle 7; LSB_FIRST=0 -> 8'h1B.
REQ-030 8 symbols, READY low 5 cycles while first byte valid: BYTE stable, RAM_EN=0 throughout stall, second byte correct, exactly 2 transfers.
REQ-031 START_ADDR=8190, LAST_ADDR=1: RAM_ADDR sequence 8190, 8191, 0, 1; single byte, DONE once.
REQ-032 START_ADDR=0, LAST_ADDR=4, all symbols 3: bytes 8'hFF then 8'h03 (LSB_FIRST=1).
REQ-033 RST_N low during second byte: all outputs reset values same cycle; new START after release yields correct first byte.
REQ-034 START pulsed while BUSY and in DONE cycle: no effect; byte count and addresses match single run.

Source files
------------

// File: rtl/ram2_pkg.sv
// Shared widths and FSM state type for the 2-bit RAM to byte reader.
package ram2_pkg;

   localparam int unsigned ADDR_W        = 13;
   localparam int unsigned SYM_W         = 2;
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned SYMS_PER_BYTE = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDrain
   } state_e;

endpackage

// File: rtl/sym_packer.sv
// Packs 2-bit symbols into a byte; emits on the 4th symbol or on the run's last symbol.
module sym_packer
   import ram2_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,   // sym_i is consumed this cycle
   input  logic              last_i,   // sym_i is the final symbol of the run
   input  logic [SYM_W-1:0]  sym_i,
   output logic              emit_o,   // byte_o is complete this cycle
   output logic [BYTE_W-1:0] byte_o
);

   logic [1:0]        cnt_q, cnt_d;
   logic [BYTE_W-1:0] part_q, part_d;
   logic [2:0]        pos;
   logic [BYTE_W-1:0] merged;

   // Merge the incoming symbol into its slot and decide whether the byte is finished.
   always_comb begin
      pos            = LSB_FIRST ? {cnt_q, 1'b0} : (3'd6 - {cnt_q, 1'b0});
      merged         = part_q;
      merged[pos +: SYM_W] = sym_i;
      emit_o         = push_i && ((cnt_q == 2'(SYMS_PER_BYTE - 1)) || last_i);
      byte_o         = merged;
      cnt_d          = cnt_q;
      part_d         = part_q;
      if (push_i) begin
         if (emit_o) begin
            // Unfilled slots of a short final byte stay zero because the partial clears here.
            cnt_d  = 2'd0;
            part_d = '0;
         end else begin
            cnt_d  = cnt_q + 2'd1;
            part_d = merged;
         end
      end
   end

   // Partial byte and slot counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= 2'd0;
         part_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         part_q <= part_d;
      end
   end

endmodule

// File: rtl/ram2_byte_reader.sv
// Streams a 2-bit RAM address range out as packed bytes over a valid/ready port.
module ram2_byte_reader
   import ram2_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_ADDR = 13'd0,
   parameter logic [ADDR_W-1:0] LAST_ADDR  = 13'd8191,
   parameter bit                LSB_FIRST  = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic              ram_ssr_o,
   input  logic [SYM_W-1:0]  ram_do_i,
   output logic [BYTE_W-1:0] byte_o,
   output logic              byte_valid_o,
   input  logic              byte_ready_i
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              pend_q, pend_d;           // RAM_DO holds an unconsumed symbol
   logic              pend_last_q, pend_last_d; // that symbol came from LAST_ADDR
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic              valid_q, valid_d;
   logic              last_byte_q, last_byte_d; // presented byte is the run's final byte
   logic              done_q, done_d;

   logic              adv, issue, consume, xfer, emit;
   logic [BYTE_W-1:0] packed_byte;

   // Everything moves only when the output slot can accept a new byte.
   assign adv     = !valid_q || byte_ready_i;
   assign issue   = (state_q == StRead);
   assign consume = adv && pend_q;
   assign xfer    = valid_q && byte_ready_i;

   sym_packer #(
      .LSB_FIRST (LSB_FIRST)
   ) u_sym_packer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (consume),
      .last_i (pend_last_q),
      .sym_i  (ram_do_i),
      .emit_o (emit),
      .byte_o (packed_byte)
   );

   // Next-state for the run FSM, address issue and output byte handshake.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pend_d      = pend_q;
      pend_last_d = pend_last_q;
      byte_d      = byte_q;
      valid_d     = valid_q;
      last_byte_d = last_byte_q;
      done_d      = 1'b0;
      case (state_q)
         StIdle: begin
            // done_q keeps BUSY high for the DONE cycle, so a START there is dropped.
            if (start_i && !done_q) begin
               state_d = StRead;
               addr_d  = START_ADDR;
            end
         end
         StRead: begin
            if (adv) begin
               addr_d      = addr_q + ADDR_W'(1);
               pend_d      = 1'b1;
               pend_last_d = (addr_q == LAST_ADDR);
               if (addr_q == LAST_ADDR) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (adv) begin
               pend_d      = 1'b0;
               pend_last_d = 1'b0;
            end
            if (xfer && last_byte_q) begin
               state_d     = StIdle;
               done_d      = 1'b1;
               last_byte_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
      if (xfer) begin
         valid_d = 1'b0;
      end
      if (emit) begin
         valid_d     = 1'b1;
         byte_d      = packed_byte;
         last_byte_d = pend_last_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         byte_q      <= '0;
         valid_q     <= 1'b0;
         last_byte_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         byte_q      <= byte_d;
         valid_q     <= valid_d;
         last_byte_q <= last_byte_d;
         done_q      <= done_d;
      end
   end

   assign ram_en_o     = adv && (issue || pend_q);
   assign ram_addr_o   = addr_q;
   assign ram_we_o     = 1'b0;
   assign ram_ssr_o    = 1'b0;
   assign byte_o       = byte_q;
   assign byte_valid_o = valid_q;
   assign done_o       = done_q;
   assign busy_o       = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_ram2_byte_reader.sv
// Bench for ram2_byte_reader: several parameterisations share one RAM image and stimulus.
module tb_ram2_byte_reader;

   localparam int NDUT = 6;

   function automatic int sa_of(int g);
      case (g)
         3:       return 8190;
         5:       return 100;
         default: return 0;
      endcase
   endfunction

   function automatic int la_of(int g);
      case (g)
         0, 1:    return 3;
         2:       return 7;
         3:       return 1;
         4:       return 4;
         default: return 140;
      endcase
   endfunction

   function automatic bit lsb_of(int g);
      return !(g == 1 || g == 5);
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic ready = 1'b1;

   logic        busy   [NDUT];
   logic        done   [NDUT];
   logic [12:0] raddr  [NDUT];
   logic        ren    [NDUT];
   logic        rwe    [NDUT];
   logic        rssr   [NDUT];
   logic [7:0]  bout   [NDUT];
   logic        bvalid [NDUT];

   logic [1:0] mem [8192];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      logic [1:0] do_q = 2'd0;
      // Registered-output block RAM model: one-cycle latency, holds when not enabled.
      always @(posedge clk) if (ren[g]) do_q <= mem[raddr[g]];

      ram2_byte_reader #(
         .START_ADDR (13'(sa_of(g))),
         .LAST_ADDR  (13'(la_of(g))),
         .LSB_FIRST  (lsb_of(g))
      ) u_dut (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .start_i      (start),
         .busy_o       (busy[g]),
         .done_o       (done[g]),
         .ram_addr_o   (raddr[g]),
         .ram_en_o     (ren[g]),
         .ram_we_o     (rwe[g]),
         .ram_ssr_o    (rssr[g]),
         .ram_do_i     (do_q),
         .byte_o       (bout[g]),
         .byte_valid_o (bvalid[g]),
         .byte_ready_i (ready)
      );
   end

   int checks = 0;
   int errors = 0;

   logic [7:0]  got_bytes [$];
   logic [12:0] got_addrs [$];
   logic [7:0]  exp_bytes [$];
   int exp_n;
   int first_valid, done_cyc, done_cnt, busy_bad, stable_bad, en_stall, stall_cyc;
   logic post_busy, post_done;

   // Reference model: symbol k of the run sits in slot k%4 of byte k/4.
   task automatic build_exp(input int g);
      int s, l, slot, sh;
      logic [7:0] b;
      exp_bytes.delete();
      s = sa_of(g);
      l = la_of(g);
      exp_n = ((l - s + 8192) % 8192) + 1;
      b = 8'd0;
      for (int k = 0; k < exp_n; k++) begin
         slot = k % 4;
         sh   = lsb_of(g) ? 2 * slot : 6 - 2 * slot;
         b    = b | (8'(mem[(s + k) % 8192]) << sh);
         if (slot == 3 || k == exp_n - 1) begin
            exp_bytes.push_back(b);
            b = 8'd0;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Runs one START on instance g and records what the DUT did.
   // rmode 0: ready always high; 1: random ready; 2: hold off the first byte for 5 cycles.
   task automatic run(input int g, input int rmode, input bit poke);
      int cyc;
      bit v, prev_hold;
      logic [7:0] prev_byte;
      got_bytes.delete();
      got_addrs.delete();
      first_valid = -1; done_cyc = -1; done_cnt = 0; busy_bad = 0;
      stable_bad = 0; en_stall = 0; stall_cyc = 0;
      post_busy = 1'bx; post_done = 1'bx;
      prev_hold = 1'b0; prev_byte = 8'd0;
      @(negedge clk);
      start = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      forever begin
         #1;
         v = bvalid[g];
         case (rmode)
            0:       ready = 1'b1;
            1:       ready = ($urandom_range(0, 2) != 0);
            default: ready = !(v && got_bytes.size() == 0 && stall_cyc < 5);
         endcase
         #1;
         if (v && !ready) begin
            stall_cyc++;
            if (ren[g]) en_stall++;
         end
         if (prev_hold && (bout[g] !== prev_byte || !v)) stable_bad++;
         prev_hold = v && !ready;
         prev_byte = bout[g];
         if (busy[g] !== 1'b1) busy_bad++;
         if (ren[g]) got_addrs.push_back(raddr[g]);
         if (v && first_valid < 0) first_valid = cyc;
         if (v && ready) got_bytes.push_back(bout[g]);
         if (done[g] === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            post_busy = busy[g];
            post_done = done[g];
            break;
         end
         start = (poke && cyc == 3);
         cyc++;
         if (cyc > 3000) begin
            checks++; errors++;
            $display("FAIL timeout dut=%0d no DONE within 3000 cycles", g);
            start = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      #1;
      for (int g = 0; g < NDUT; g++) begin
         checks++;
         if ({busy[g], done[g], bvalid[g], ren[g], rwe[g], rssr[g]} !== 6'b0 ||
             bout[g] !== 8'd0 || raddr[g] !== 13'd0) begin
            errors++;
            $display("FAIL reset_state dut=%0d busy=%b done=%b valid=%b en=%b we=%b ssr=%b byte=%h addr=%0d, want all 0",
                     g, busy[g], done[g], bvalid[g], ren[g], rwe[g], rssr[g], bout[g], raddr[g]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      for (int g = 0; g < 2; g++) begin
         do_reset();
         for (int i = 0; i < 4; i++) mem[i] = 2'(i);
         build_exp(g);
         run(g, 0, 1'b0);
         checks++;
         if (got_bytes.size() != 1 || got_bytes[0] !== exp_bytes[0]) begin
            errors++;
            $display("FAIL basic_byte dut=%0d got n=%0d b=%h want n=1 b=%h", g, got_bytes.size(),
                     (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx, exp_bytes[0]);
         end
         checks++;
         if (first_valid != 6 || done_cyc != 7) begin
            errors++;
            $display("FAIL basic_timing dut=%0d valid_cyc=%0d done_cyc=%0d want 6 and 7", g,
                     first_valid, done_cyc);
         end
         checks++;
         if (busy_bad != 0 || post_busy !== 1'b0 || post_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy dut=%0d busy_low_cycles=%0d after_done busy=%b done=%b want 0",
                     g, busy_bad, post_busy, post_done);
         end
         checks++;
         if (got_addrs.size() != 5) begin
            errors++;
            $display("FAIL basic_en_count dut=%0d got %0d want 5", g, got_addrs.size());
         end
         for (int i = 0; i < 4 && i < got_addrs.size(); i++) begin
            checks++;
            if (got_addrs[i] !== 13'(i)) begin
               errors++;
               $display("FAIL basic_addr dut=%0d idx=%0d got %0d want %0d", g, i, got_addrs[i], i);
            end
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int i = 0; i < 8; i++) mem[i] = 2'($urandom_range(0, 3));
      build_exp(2);
      run(2, 2, 1'b0);
      checks++;
      if (stall_cyc != 5 || en_stall != 0 || stable_bad != 0) begin
         errors++;
         $display("FAIL stall_hold stall=%0d en_during_stall=%0d unstable=%0d want 5 0 0",
                  stall_cyc, en_stall, stable_bad);
      end
      checks++;
      if (got_bytes.size() != 2) begin
         errors++;
         $display("FAIL stall_count got %0d want 2", got_bytes.size());
      end
      for (int i = 0; i < 2 && i < got_bytes.size(); i++) begin
         checks++;
         if (got_bytes[i] !== exp_bytes[i]) begin
            errors++;
            $display("FAIL stall_byte idx=%0d got %h want %h", i, got_bytes[i], exp_bytes[i]);
         end
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL stall_done got %0d want 1", done_cnt);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      mem[8190] = 2'd1; mem[8191] = 2'd2; mem[0] = 2'd3; mem[1] = 2'd0;
      build_exp(3);
      run(3, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= got_addrs.size() || got_addrs[i] !== 13'((8190 + i) % 8192)) begin
            errors++;
            $display("FAIL wrap_addr idx=%0d got %0d want %0d", i,
                     (i < got_addrs.size()) ? got_addrs[i] : 13'h1fff, (8190 + i) % 8192);
         end
      end
      checks++;
      if (got_bytes.size() != 1 || got_bytes[0] !== exp_bytes[0] || done_cnt != 1) begin
         errors++;
         $display("FAIL wrap_byte n=%0d b=%h done=%0d want n=1 b=%h done=1", got_bytes.size(),
                  (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx, done_cnt, exp_bytes[0]);
      end
   endtask

   task automatic test_partial();
      do_reset();
      for (int i = 0; i < 5; i++) mem[i] = 2'd3;
      build_exp(4);
      run(4, 0, 1'b0);
      checks++;
      if (got_bytes.size() != 2 || got_bytes[0] !== 8'hFF || got_bytes[1] !== 8'h03) begin
         errors++;
         $display("FAIL partial_bytes n=%0d b0=%h b1=%h want n=2 FF 03", got_bytes.size(),
                  (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx,
                  (got_bytes.size() > 1) ? got_bytes[1] : 8'hxx);
      end
      checks++;
      if (exp_bytes.size() != 2 || done_cnt != 1) begin
         errors++;
         $display("FAIL partial_done model_n=%0d done=%0d want 2 1", exp_bytes.size(), done_cnt);
      end
   endtask

   task automatic test_random();
      int g;
      for (int it = 0; it < 4; it++) begin
         g = (it % 2 == 0) ? 5 : 2;
         do_reset();
         for (int i = 0; i < 8192; i++) mem[i] = 2'($urandom_range(0, 3));
         build_exp(g);
         run(g, 1, 1'b0);
         checks++;
         if (got_bytes.size() != exp_bytes.size() || done_cnt != 1) begin
            errors++;
            $display("FAIL rand_count dut=%0d got n=%0d done=%0d want n=%0d done=1", g,
                     got_bytes.size(), done_cnt, exp_bytes.size());
         end
         for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
            checks++;
            if (got_bytes[i] !== exp_bytes[i]) begin
               errors++;
               $display("FAIL rand_byte dut=%0d idx=%0d got %h want %h", g, i, got_bytes[i],
                        exp_bytes[i]);
            end
         end
         checks++;
         if (en_stall != 0 || stable_bad != 0 || busy_bad != 0 || got_addrs.size() != exp_n + 1)
         begin
            errors++;
            $display("FAIL rand_protocol dut=%0d en_stall=%0d unstable=%0d busy_low=%0d en_n=%0d want 0 0 0 %0d",
                     g, en_stall, stable_bad, busy_bad, got_addrs.size(), exp_n + 1);
         end
      end
   endtask

   task automatic test_start_ignored();
      do_reset();
      for (int i = 0; i < 4; i++) mem[i] = 2'(3 - i);
      build_exp(0);
      run(0, 0, 1'b1);
      checks++;
      if (got_bytes.size() != 1 || got_bytes[0] !== exp_bytes[0] || done_cnt != 1) begin
         errors++;
         $display("FAIL ignore_byte n=%0d done=%0d want n=1 b=%h done=1", got_bytes.size(),
                  done_cnt, exp_bytes[0]);
      end
      checks++;
      if (got_addrs.size() != 5 || post_busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_restart en_n=%0d busy_after_done=%b want 5 0", got_addrs.size(),
                  post_busy);
      end
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (busy[0] !== 1'b0 || ren[0] !== 1'b0) begin
         errors++;
         $display("FAIL ignore_idle busy=%b en=%b want 0 0", busy[0], ren[0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 8; i++) mem[i] = 2'($urandom_range(0, 3));
      mem[0] = 2'd1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy[2] !== 1'b0 || done[2] !== 1'b0 || bvalid[2] !== 1'b0 || bout[2] !== 8'd0 ||
          ren[2] !== 1'b0 || raddr[2] !== 13'd0) begin
         errors++;
         $display("FAIL midrun_reset busy=%b done=%b valid=%b byte=%h en=%b addr=%0d want all 0",
                  busy[2], done[2], bvalid[2], bout[2], ren[2], raddr[2]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) mem[i] = 2'($urandom_range(0, 3));
      build_exp(2);
      run(2, 0, 1'b0);
      checks++;
      if (got_bytes.size() != 2 || got_bytes[0] !== exp_bytes[0] || got_bytes[1] !== exp_bytes[1]
          || first_valid != 6) begin
         errors++;
         $display("FAIL midrun_restart n=%0d b0=%h valid_cyc=%0d want n=2 b0=%h cyc=6",
                  got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx, first_valid,
                  exp_bytes[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 2'd0;
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_partial();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
